sgm_census_ingest: RTL and testbench

- Downstream of the img_in AXI4-Lite register slave; consumes the 32-bit pixel words the host writes there.
- Unpacks each word into four 8-bit grey pixels in raster order and runs a 3x3 census transform using two internal line buffers.
- Emits one 8-bit census code per pixel on a valid/ready stream to the SGM cost stage, with an end-of-frame marker.

---
 rtl/sgm_pkg.sv | 23 ++
 rtl/sgm_line_buffer.sv | 24 ++
 rtl/sgm_census_ingest.sv | 165 ++++++++++++++++
 tb/tb_sgm_census_ingest.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sgm_pkg.sv
// Shared types and constants for the census ingest block.
package sgm_pkg;

  localparam int PIX_W        = 8;
  localparam int PIX_PER_WORD = 4;

  // Census bit index for each 3x3 window slot in raster order; slot 4 is the centre and unused.
  localparam logic [8:0][2:0] CENSUS_BIT = {3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd4, 3'd5, 3'd6, 3'd7};

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

  // One window column: rows r-1 (t), r (m), r+1 (b) relative to the centre row.
  typedef struct packed {
    logic [PIX_W-1:0] t;
    logic [PIX_W-1:0] m;
    logic [PIX_W-1:0] b;
  } col_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sgm_line_buffer.sv
// One image row of pixels: synchronous write, asynchronous read, addressed by column.
module sgm_line_buffer
  import sgm_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int AW = cnt_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [PIX_W-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [PIX_W-1:0] rdata_o
);

  logic [PIX_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sgm_census_ingest.sv
// Unpacks host pixel words, runs a 3x3 census over a streaming window and emits
// one code per pixel in raster order with an end-of-frame marker.
module sgm_census_ingest
  import sgm_pkg::*;
#(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 48
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             frame_start_i,
  input  logic             s_word_valid_i,
  input  logic [31:0]      s_word_data_i,
  output logic             s_word_ready_o,
  output logic             m_census_valid_o,
  output logic [PIX_W-1:0] m_census_data_o,
  output logic             m_census_last_o,
  input  logic             m_census_ready_i,
  output logic             busy_o
);

  localparam int CW = cnt_w(IMG_WIDTH);
  localparam int RW = cnt_w(IMG_HEIGHT);
  localparam int FW = cnt_w(IMG_WIDTH + 2);
  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_HEIGHT - 1);
  localparam logic [FW-1:0] FILL       = FW'(IMG_WIDTH + 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(IMG_WIDTH);
  localparam logic [1:0]    SLOT_LAST  = 2'(PIX_PER_WORD - 1);

  state_e state_q, state_d;

  logic [PIX_PER_WORD-1:0][PIX_W-1:0] word_q;
  logic                 wfull_q;
  logic [1:0]           slot_q;
  logic [CW-1:0]        icol_q, ocol_q;
  logic [RW-1:0]        irow_q, orow_q;
  logic [FW-1:0]        fill_q, flush_q;
  col_t [1:0]           win_q;
  logic                 oval_q, olast_q;
  logic [PIX_W-1:0]     odata_q;

  logic             pix_avail, adv, emit, word_rdy, word_acc, border, last;
  logic [PIX_W-1:0] pix, lb1_rd, lb2_rd, code;
  logic [7:0]       raw;
  logic [PIX_W-1:0] nb [9];
  col_t             newcol;

  // FLUSH feeds zeros so the last row's codes drain without further input.
  assign pix_avail = (state_q == RUN && wfull_q) || state_q == FLUSH;
  assign adv       = pix_avail && (!oval_q || m_census_ready_i);
  assign pix       = (state_q == FLUSH) ? '0 : word_q[slot_q];
  assign emit      = (fill_q == FILL);
  assign word_acc  = word_rdy && s_word_valid_i;
  assign newcol    = '{t: lb2_rd, m: lb1_rd, b: pix};

  sgm_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
    .clk_i(clock_i), .we_i(adv), .waddr_i(icol_q), .wdata_i(pix),
    .raddr_i(icol_q), .rdata_o(lb1_rd)
  );

  sgm_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb2 (
    .clk_i(clock_i), .we_i(adv), .waddr_i(icol_q), .wdata_i(lb1_rd),
    .raddr_i(icol_q), .rdata_o(lb2_rd)
  );

  always_comb begin
    nb = '{win_q[1].t, win_q[0].t, newcol.t,
           win_q[1].m, win_q[0].m, newcol.m,
           win_q[1].b, win_q[0].b, newcol.b};
    raw = '0;
    for (int i = 0; i < 9; i++) begin
      if (i != 4 && nb[i] < nb[4]) raw[CENSUS_BIT[i]] = 1'b1;
    end
  end

  // Border centres also hide row wrap and the uninitialised line buffers.
  assign border = (orow_q == '0) || (orow_q == ROW_LAST) ||
                  (ocol_q == '0) || (ocol_q == COL_LAST);
  assign code   = border ? '0 : raw;
  assign last   = (orow_q == ROW_LAST) && (ocol_q == COL_LAST);

  always_comb begin
    state_d  = state_q;
    word_rdy = 1'b0;
    case (state_q)
      IDLE:  if (frame_start_i) state_d = RUN;
      RUN: begin
        word_rdy = !wfull_q || (adv && slot_q == SLOT_LAST);
        if (adv && icol_q == COL_LAST && irow_q == ROW_LAST) state_d = FLUSH;
      end
      FLUSH: if (adv && flush_q == FLUSH_LAST) state_d = DONE;
      DONE:  if (!oval_q || m_census_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      word_q  <= '0;
      wfull_q <= 1'b0;
      slot_q  <= '0;
      icol_q  <= '0;
      irow_q  <= '0;
      ocol_q  <= '0;
      orow_q  <= '0;
      fill_q  <= '0;
      flush_q <= '0;
      win_q   <= '0;
      oval_q  <= 1'b0;
      odata_q <= '0;
      olast_q <= 1'b0;
    end else begin
      if (state_q == IDLE && frame_start_i) begin
        wfull_q <= 1'b0;
        slot_q  <= '0;
        icol_q  <= '0;
        irow_q  <= '0;
        ocol_q  <= '0;
        orow_q  <= '0;
        fill_q  <= '0;
        flush_q <= '0;
      end
      if (word_acc) begin
        word_q  <= s_word_data_i;
        wfull_q <= 1'b1;
        slot_q  <= '0;
      end else if (adv && state_q == RUN) begin
        slot_q <= slot_q + 1'b1;
        if (slot_q == SLOT_LAST) wfull_q <= 1'b0;
      end
      if (adv) begin
        win_q[1] <= win_q[0];
        win_q[0] <= newcol;
        icol_q   <= (icol_q == COL_LAST) ? '0 : icol_q + 1'b1;
        if (icol_q == COL_LAST) irow_q <= (irow_q == ROW_LAST) ? '0 : irow_q + 1'b1;
        if (!emit) fill_q <= fill_q + 1'b1;
        if (state_q == FLUSH) flush_q <= flush_q + 1'b1;
        if (emit) begin
          ocol_q <= (ocol_q == COL_LAST) ? '0 : ocol_q + 1'b1;
          if (ocol_q == COL_LAST) orow_q <= (orow_q == ROW_LAST) ? '0 : orow_q + 1'b1;
        end
      end
      if (adv && emit) begin
        oval_q  <= 1'b1;
        odata_q <= code;
        olast_q <= last;
      end else if (m_census_ready_i) begin
        oval_q <= 1'b0;
      end
    end
  end

  assign s_word_ready_o   = word_rdy;
  assign m_census_valid_o = oval_q;
  assign m_census_data_o  = odata_q;
  assign m_census_last_o  = olast_q;
  assign busy_o           = (state_q != IDLE);

endmodule

// File: tb/tb_sgm_census_ingest.sv
// Directed bench for sgm_census_ingest on an 8x4 frame.
module tb_sgm_census_ingest;

  localparam int W = 8, H = 4, NPIX = W * H, BUDGET = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, fs = 1'b0, sv = 1'b0, mr = 1'b1;
  logic [31:0] sd = '0;
  logic sr, mv, ml, busy;
  logic [7:0] md;

  sgm_census_ingest #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clock_i(clk), .reset_i(rst), .frame_start_i(fs),
    .s_word_valid_i(sv), .s_word_data_i(sd), .s_word_ready_o(sr),
    .m_census_valid_o(mv), .m_census_data_o(md), .m_census_last_o(ml),
    .m_census_ready_i(mr), .busy_o(busy)
  );

  logic [7:0] img [H][W];
  logic [7:0] got [NPIX];
  int n_tests = 0, n_fail = 0;
  int ncodes, stab_bad, last_bad, extras;
  logic busy_after;

  task automatic set_img(input int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (kind)
          0: img[r][c] = 8'h40;
          1: img[r][c] = 8'(c);
          2: img[r][c] = (r == 1 && c == 1) ? 8'hFF : 8'h10;
          default: img[r][c] = 8'((r * 37 + c * 11) ^ (c << 4));
        endcase
  endtask

  function automatic logic [31:0] word_at(input int w);
    int r, c;
    r = (w * 4) / W;
    c = (w * 4) % W;
    return {img[r][c+3], img[r][c+2], img[r][c+1], img[r][c]};
  endfunction

  task automatic drive(input int gap, input int fs_at);
    for (int w = 0; w < NPIX / 4; w++) begin
      int cyc;
      logic acc;
      if (gap != 0 && w % 2 == 1) begin
        sv = 1'b0;
        @(posedge clk); #1;
      end
      if (w == fs_at) fs = 1'b1;
      sd = word_at(w);
      sv = 1'b1;
      cyc = 0;
      do begin
        @(negedge clk); acc = sr;
        @(posedge clk); #1; fs = 1'b0; cyc++;
      end while (!acc && cyc < BUDGET);
    end
    sv = 1'b0;
  endtask

  task automatic collect(input int stall);
    int cyc = 0, n = 0;
    logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [7:0] pd = '0;
    stab_bad = 0;
    last_bad = 0;
    while (n < NPIX && cyc < BUDGET) begin
      mr = (stall != 0) ? (cyc % 2 == 1) : 1'b1;
      @(negedge clk);
      if (pv && !pr && (!mv || md !== pd || ml !== pl)) stab_bad++;
      if (mv && mr) begin
        got[n] = md;
        if (ml !== (n == NPIX - 1)) last_bad++;
        n++;
      end
      pv = mv; pr = mr; pd = md; pl = ml;
      @(posedge clk); #1; cyc++;
    end
    ncodes = n;
    mr = 1'b1;
  endtask

  task automatic run_frame(input int gap, input int stall, input int fs_at);
    for (int i = 0; i < NPIX; i++) got[i] = 8'hxx;
    fs = 1'b1;
    @(posedge clk); #1;
    fs = 1'b0;
    fork
      drive(gap, fs_at);
      collect(stall);
    join
    busy_after = busy;
    extras = 0;
    repeat (10) begin
      @(negedge clk);
      if (mv) extras++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({mv, md, ml, busy, sr} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b d=%h l=%b busy=%b rdy=%b need all 0", mv, md, ml, busy, sr);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_flat;
    set_img(0);
    run_frame(0, 0, -1);
    n_tests++;
    if (ncodes !== NPIX) begin n_fail++; $display("FAIL flat_count got %0d need %0d", ncodes, NPIX); end
    for (int i = 0; i < NPIX; i++) begin
      n_tests++;
      if (got[i] !== 8'h00) begin n_fail++; $display("FAIL flat_code[%0d] got %h need 00", i, got[i]); end
    end
    n_tests++;
    if (last_bad !== 0) begin n_fail++; $display("FAIL flat_last got %0d bad flags need 0", last_bad); end
    n_tests++;
    if (busy_after !== 1'b0) begin n_fail++; $display("FAIL flat_busy_drop got %b need 0", busy_after); end
  endtask

  task automatic test_ramp;
    set_img(1);
    run_frame(0, 0, -1);
    n_tests++;
    if (ncodes !== NPIX) begin n_fail++; $display("FAIL ramp_count got %0d need %0d", ncodes, NPIX); end
    for (int i = 0; i < NPIX; i++) begin
      int r = i / W, c = i % W;
      logic [7:0] exp = (r == 0 || r == H - 1 || c == 0 || c == W - 1) ? 8'h00 : 8'h94;
      n_tests++;
      if (got[i] !== exp) begin n_fail++; $display("FAIL ramp_code[%0d] got %h need %h", i, got[i], exp); end
    end
  endtask

  task automatic test_bright;
    set_img(2);
    run_frame(0, 0, -1);
    n_tests++;
    if (got[1*W+1] !== 8'hFF) begin n_fail++; $display("FAIL bright_c11 got %h need ff", got[1*W+1]); end
    n_tests++;
    if (got[2*W+2] !== 8'h00) begin n_fail++; $display("FAIL bright_c22 got %h need 00", got[2*W+2]); end
    n_tests++;
    if (got[1*W+2] !== 8'h00) begin n_fail++; $display("FAIL bright_c12 got %h need 00", got[1*W+2]); end
    for (int i = 0; i < NPIX; i++) begin
      n_tests++;
      if (got[i] !== ((i == 1*W+1) ? 8'hFF : 8'h00)) begin
        n_fail++; $display("FAIL bright_code[%0d] got %h", i, got[i]);
      end
    end
    n_tests++;
    if (last_bad !== 0) begin n_fail++; $display("FAIL bright_last got %0d bad flags need 0", last_bad); end
  endtask

  task automatic test_backpressure;
    set_img(3);
    run_frame(1, 1, -1);
    n_tests++;
    if (ncodes !== NPIX || extras !== 0) begin
      n_fail++; $display("FAIL bp_count got %0d codes %0d extra need %0d 0", ncodes, extras, NPIX);
    end
    n_tests++;
    if (stab_bad !== 0) begin n_fail++; $display("FAIL bp_stable got %0d changes need 0", stab_bad); end
    n_tests++;
    if (last_bad !== 0) begin n_fail++; $display("FAIL bp_last got %0d bad flags need 0", last_bad); end
    for (int i = 0; i < NPIX; i++) begin
      int r = i / W, c = i % W, k = 7;
      logic [7:0] exp = '0;
      if (!(r == 0 || r == H - 1 || c == 0 || c == W - 1))
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0) begin
              exp[k] = img[r+dr][c+dc] < img[r][c];
              k--;
            end
      n_tests++;
      if (got[i] !== exp) begin n_fail++; $display("FAIL bp_code[%0d] got %h need %h", i, got[i], exp); end
    end
  endtask

  task automatic test_reset_mid;
    set_img(1);
    fs = 1'b1;
    @(posedge clk); #1;
    fs = 1'b0;
    for (int w = 0; w < 5; w++) begin
      int cyc = 0;
      logic acc;
      sd = word_at(w);
      sv = 1'b1;
      do begin
        @(negedge clk); acc = sr;
        @(posedge clk); #1; cyc++;
      end while (!acc && cyc < BUDGET);
    end
    sv = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({mv, md, ml, busy, sr} !== 12'h000) begin
      n_fail++;
      $display("FAIL midreset_outputs got v=%b d=%h l=%b busy=%b rdy=%b need all 0", mv, md, ml, busy, sr);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    run_frame(0, 0, -1);
    n_tests++;
    if (ncodes !== NPIX) begin n_fail++; $display("FAIL midreset_count got %0d need %0d", ncodes, NPIX); end
    for (int i = 0; i < NPIX; i++) begin
      int r = i / W, c = i % W;
      logic [7:0] exp = (r == 0 || r == H - 1 || c == 0 || c == W - 1) ? 8'h00 : 8'h94;
      n_tests++;
      if (got[i] !== exp) begin n_fail++; $display("FAIL midreset_code[%0d] got %h need %h", i, got[i], exp); end
    end
  endtask

  task automatic test_frame_start_ignored;
    set_img(1);
    run_frame(0, 0, 3);
    n_tests++;
    if (ncodes !== NPIX || extras !== 0) begin
      n_fail++; $display("FAIL fsmid_count got %0d codes %0d extra need %0d 0", ncodes, extras, NPIX);
    end
    n_tests++;
    if (last_bad !== 0) begin n_fail++; $display("FAIL fsmid_last got %0d bad flags need 0", last_bad); end
    n_tests++;
    if (got[2*W+5] !== 8'h94 || got[3*W+5] !== 8'h00) begin
      n_fail++; $display("FAIL fsmid_codes got %h %h need 94 00", got[2*W+5], got[3*W+5]);
    end
  endtask

  initial begin
    test_reset;
    test_flat;
    test_ramp;
    test_bright;
    test_backpressure;
    test_reset_mid;
    test_frame_start_ignored;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
